id_decode_buffer: RTL and testbench
===================================

// Module: id_decode_buffer
// PURPOSE
//  Instruction decode buffer between IF and ID of the MIPS core.
//  - Accepts fetched {inst, pc} pairs over a valid/ready handshake.
//  - Decodes each one into the 12-bit main control word plus a reserved-instruction flag at enqueue.
//  - Holds up to DEPTH decoded entries, presented in order on a valid/ready output.
//  - Adds buffering, backpressure and flush on top of a purely combinational main decode.
// PARAMETERS
//  DEPTH   4   FIFO entries; power of two, >= 2
//  PC_W    32  width of the pc field
// PORTS
//  clk        in   1     clock
//  rst        in   1     synchronous reset, active-high
//  flush      in   1     discard all entries (branch/exception redirect)
//  in_valid   in   1     fetch offers in_inst/in_pc
//  in_ready   out  1     buffer can accept this cycle
//  in_inst    in   32    instruction word
//  in_pc      in   PC_W  its pc
//  out_valid  out  1     head entry valid
//  out_ready  in   1     ID consumes head this cycle
//  out_inst   out  32    head instruction
//  out_pc     out  PC_W  head pc
//  out_ctrl   out  12    [0:11] = reg_write, reg_dst[1:2] (00 rt, 01 rd, 10 r31), alu_src_pc,
//                        alu_src_imm, mem_to_reg, hilo_read, hilo_write, branch, unsign_ext, jump, load
//  out_ri     out  1     head is a reserved/unknown instruction
//  count      out  $clog2(DEPTH)+1  entries held
// BEHAVIOUR
//  - Reset: count=0, pointers=0, out_valid=0, all entry valid bits cleared.
//  - Data outputs are forced to 0 whenever out_valid=0; this also holds after reset.
//  - Handshake:
//    - push = in_valid & in_ready, with in_ready = (count != DEPTH).
//    - pop = out_valid & out_ready, with out_valid = (count != 0).
//    - Push and pop in the same cycle are allowed; count is unchanged, both pointers advance.
//    - When full, in_ready=0 even if a pop occurs; there is no full-bypass.
//  - Latency: an entry pushed in cycle N appears on out_* in cycle N+1 at the earliest; there is no empty-bypass.
//  - Pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
//  - flush: in the next cycle count=0, pointers=0, out_valid=0.
//    - A push in the flush cycle is dropped.
//    - rst has priority over flush.
//  - Decode is combinational on in_inst; the result is stored with the entry.
//    - op=[31:26], rt=[20:16], funct=[5:0].
//  - Decode table; control word listed as bit0..11:
//    - R (op 000000), funct:
//      - MTHI/MTLO 010001/010011 -> 0_00_0_0_0_1_1_0_0_0_0
//      - MFHI/MFLO 010000/010010 -> 1_01_0_0_0_1_0_0_0_0_0
//      - MULT/MULTU/DIV/DIVU 0110xx -> 1_01_0_0_0_0_1_0_0_0_0
//      - JR 001000 -> 0_00_0_0_0_0_0_0_0_1_0
//      - JALR 001001 -> 1_01_1_0_0_0_0_0_0_1_0
//      - SLL 000000 -> all-zero when inst==0 (nop), else 1_01_0_0_0_0_0_0_0_0_0
//      - Other defined ALU functs (SRL, SRA, SLLV, SRLV, SRAV, ADD, ADDU, SUB, SUBU, AND, OR, XOR, NOR, SLT, SLTU)
//        -> 1_01_0_0_0_0_0_0_0_0_0
//      - Any other funct -> ri=1
//    - ADDI/ADDIU/SLTI/SLTIU 0010xx (excluding 001100-001111) -> 1_00_0_1_0_0_0_0_0_0_0
//    - ANDI/ORI/XORI/LUI 0011xx -> 1_00_0_1_0_0_0_0_1_0_0
//    - LB/LH/LW/LBU/LHU 100000/100001/100011/100100/100101 -> 1_00_0_1_1_0_0_0_0_0_1
//    - SB/SH/SW 101000/101001/101011 -> 0_00_0_1_0_0_0_0_0_0_0
//    - BEQ/BNE/BLEZ/BGTZ 0001xx -> 0_00_0_0_0_0_0_1_0_0_0
//    - REGIMM 000001, rt:
//      - BLTZ/BGEZ 00000/00001 -> as BEQ
//      - BLTZAL/BGEZAL 10000/10001 -> 1_10_1_0_0_0_0_1_0_0_0
//      - Other rt -> ri=1
//    - J 000010 -> 0_00_0_0_0_0_0_0_0_1_0
//    - JAL 000011 -> 1_10_1_0_0_0_0_0_0_1_0
//    - Any other op -> ri=1
//  - When ri=1 the control word is all-zero; the entry is still queued so ID can raise the exception.
// TESTING
//  - rst, push 4 (0x24010005@0xBFC00000, 0x8C220000, 0xAC220004, 0x0C000010); out_ready=0 -> in_ready=0 after 4th push,
//    count=4; out_ctrl of head=1_00_0_1_0_0_0_0_0_0_0.
//  - Drain with out_ready=1 -> order preserved; LW ctrl ..._1 (load), SW alu_src_imm only, JAL 1_10_1_..._1_0;
//    out_valid=0 after 4 pops.
//  - Simultaneous push/pop at count=2 for 10 cycles, pointers wrapping -> count stays 2, no loss or duplication.
//  - flush with in_valid=1 at count=3 -> next cycle count=0, out_valid=0, flushed-cycle push absent.
//  - Push 0x00000000, 0x7C000000, 0x0411FFFF -> ctrl 0 and ri=0; ctrl 0 and ri=1;
//    BGEZAL ctrl 1_10_1_0_0_0_0_1_0_0_0.
//  - Assert rst mid-stream at count=3 -> count=0, all out_* 0 next cycle.

Source files
------------

// File: rtl/id_decode_buffer.sv
// id_decode_buffer: IF/ID buffer that decodes MIPS instructions at enqueue and queues them in order
module id_decode_buffer #(
    parameter int DEPTH = 4,
    parameter int PC_W  = 32
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_inst,
    input  logic [PC_W-1:0]          in_pc,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_inst,
    output logic [PC_W-1:0]          out_pc,
    output logic [11:0]              out_ctrl,
    output logic                     out_ri,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    // Control words are written bit0 first (left) and bit-reversed into out_ctrl order
    localparam logic [11:0] C_MTHI = 12'b0_00_0_0_0_1_1_0_0_0_0;
    localparam logic [11:0] C_MFHI = 12'b1_01_0_0_0_1_0_0_0_0_0;
    localparam logic [11:0] C_MULT = 12'b1_01_0_0_0_0_1_0_0_0_0;
    localparam logic [11:0] C_JR   = 12'b0_00_0_0_0_0_0_0_0_1_0;
    localparam logic [11:0] C_JALR = 12'b1_01_1_0_0_0_0_0_0_1_0;
    localparam logic [11:0] C_ALU  = 12'b1_01_0_0_0_0_0_0_0_0_0;
    localparam logic [11:0] C_IMMA = 12'b1_00_0_1_0_0_0_0_0_0_0;
    localparam logic [11:0] C_IMML = 12'b1_00_0_1_0_0_0_0_1_0_0;
    localparam logic [11:0] C_LOAD = 12'b1_00_0_1_1_0_0_0_0_0_1;
    localparam logic [11:0] C_STOR = 12'b0_00_0_1_0_0_0_0_0_0_0;
    localparam logic [11:0] C_BR   = 12'b0_00_0_0_0_0_0_1_0_0_0;
    localparam logic [11:0] C_BAL  = 12'b1_10_1_0_0_0_0_1_0_0_0;
    localparam logic [11:0] C_J    = 12'b0_00_0_0_0_0_0_0_0_1_0;
    localparam logic [11:0] C_JAL  = 12'b1_10_1_0_0_0_0_0_0_1_0;

    function automatic logic [11:0] bits(input logic [11:0] s);
        for (int k = 0; k < 12; k++) bits[k] = s[11-k];
    endfunction

    logic [31:0]     inst_q [DEPTH];
    logic [PC_W-1:0] pc_q   [DEPTH];
    logic [11:0]     ctrl_q [DEPTH];
    logic [DEPTH-1:0] ri_q, vld_q;
    logic [AW-1:0]   wr_ptr, rd_ptr;
    logic [11:0]     raw, dec_ctrl;
    logic            dec_ri, push, pop;
    logic [5:0]      op, funct;
    logic [4:0]      rt;

    assign op    = in_inst[31:26];
    assign rt    = in_inst[20:16];
    assign funct = in_inst[5:0];

    always_comb begin
        raw    = '0;
        dec_ri = 1'b0;
        case (op)
            6'b000000:
                case (funct)
                    6'b010001, 6'b010011: raw = C_MTHI;
                    6'b010000, 6'b010010: raw = C_MFHI;
                    6'b011000, 6'b011001, 6'b011010, 6'b011011: raw = C_MULT;
                    6'b001000: raw = C_JR;
                    6'b001001: raw = C_JALR;
                    6'b000000: raw = (in_inst == '0) ? '0 : C_ALU;
                    6'b000010, 6'b000011, 6'b000100, 6'b000110, 6'b000111,
                    6'b100000, 6'b100001, 6'b100010, 6'b100011, 6'b100100,
                    6'b100101, 6'b100110, 6'b100111, 6'b101010, 6'b101011: raw = C_ALU;
                    default: dec_ri = 1'b1;
                endcase
            6'b001000, 6'b001001, 6'b001010, 6'b001011: raw = C_IMMA;
            6'b001100, 6'b001101, 6'b001110, 6'b001111: raw = C_IMML;
            6'b100000, 6'b100001, 6'b100011, 6'b100100, 6'b100101: raw = C_LOAD;
            6'b101000, 6'b101001, 6'b101011: raw = C_STOR;
            6'b000100, 6'b000101, 6'b000110, 6'b000111: raw = C_BR;
            6'b000001:
                case (rt)
                    5'b00000, 5'b00001: raw = C_BR;
                    5'b10000, 5'b10001: raw = C_BAL;
                    default: dec_ri = 1'b1;
                endcase
            6'b000010: raw = C_J;
            6'b000011: raw = C_JAL;
            default: dec_ri = 1'b1;
        endcase
        dec_ctrl = bits(raw);
    end

    assign in_ready  = (count != CW'(DEPTH));
    assign out_valid = vld_q[rd_ptr];
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            vld_q  <= '0;
        end else begin
            if (pop) begin
                vld_q[rd_ptr] <= 1'b0;
                rd_ptr        <= rd_ptr + 1'b1;
            end
            if (push) begin
                inst_q[wr_ptr] <= in_inst;
                pc_q[wr_ptr]   <= in_pc;
                ctrl_q[wr_ptr] <= dec_ctrl;
                ri_q[wr_ptr]   <= dec_ri;
                vld_q[wr_ptr]  <= 1'b1;
                wr_ptr         <= wr_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    assign out_inst = out_valid ? inst_q[rd_ptr] : '0;
    assign out_pc   = out_valid ? pc_q[rd_ptr]   : '0;
    assign out_ctrl = out_valid ? ctrl_q[rd_ptr] : '0;
    assign out_ri   = out_valid & ri_q[rd_ptr];
endmodule

// File: tb/tb_id_decode_buffer.sv
// tb_id_decode_buffer: randomized and directed checks of id_decode_buffer against a queue model
module tb_id_decode_buffer;
    localparam int DEPTH = 4;
    logic        clk = 1'b0, rst = 1'b1, flush = 1'b0;
    logic        in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, out_ri;
    logic [31:0] in_inst = '0, in_pc = '0, out_inst, out_pc;
    logic [11:0] out_ctrl;
    logic [2:0]  count;
    int checks = 0, errors = 0;

    id_decode_buffer #(.DEPTH(DEPTH), .PC_W(32)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_inst(in_inst), .in_pc(in_pc), .out_valid(out_valid), .out_ready(out_ready),
        .out_inst(out_inst), .out_pc(out_pc), .out_ctrl(out_ctrl), .out_ri(out_ri), .count(count)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] inst; logic [31:0] pc; logic [11:0] ctrl; logic ri; } ent_t;
    ent_t q[$];

    localparam logic [11:0] C_MTHI = 12'b0_00_0_0_0_1_1_0_0_0_0;
    localparam logic [11:0] C_MFHI = 12'b1_01_0_0_0_1_0_0_0_0_0;
    localparam logic [11:0] C_MULT = 12'b1_01_0_0_0_0_1_0_0_0_0;
    localparam logic [11:0] C_JR   = 12'b0_00_0_0_0_0_0_0_0_1_0;
    localparam logic [11:0] C_JALR = 12'b1_01_1_0_0_0_0_0_0_1_0;
    localparam logic [11:0] C_ALU  = 12'b1_01_0_0_0_0_0_0_0_0_0;
    localparam logic [11:0] C_IMMA = 12'b1_00_0_1_0_0_0_0_0_0_0;
    localparam logic [11:0] C_IMML = 12'b1_00_0_1_0_0_0_0_1_0_0;
    localparam logic [11:0] C_LOAD = 12'b1_00_0_1_1_0_0_0_0_0_1;
    localparam logic [11:0] C_STOR = 12'b0_00_0_1_0_0_0_0_0_0_0;
    localparam logic [11:0] C_BR   = 12'b0_00_0_0_0_0_0_1_0_0_0;
    localparam logic [11:0] C_BAL  = 12'b1_10_1_0_0_0_0_1_0_0_0;
    localparam logic [11:0] C_J    = 12'b0_00_0_0_0_0_0_0_0_1_0;
    localparam logic [11:0] C_JAL  = 12'b1_10_1_0_0_0_0_0_0_1_0;

    // Table strings list bit0 first; out_ctrl has bit0 at the LSB
    function automatic logic [11:0] sp(input logic [11:0] s);
        for (int k = 0; k < 12; k++) sp[k] = s[11-k];
    endfunction

    // Returns {ri, ctrl} straight from the instruction table
    function automatic logic [12:0] ref_dec(input logic [31:0] i);
        logic [5:0] op, f;
        logic [4:0] rt;
        op = i[31:26]; f = i[5:0]; rt = i[20:16];
        if (op == 6'h00) begin
            if (f == 6'h11 || f == 6'h13) return {1'b0, sp(C_MTHI)};
            if (f == 6'h10 || f == 6'h12) return {1'b0, sp(C_MFHI)};
            if (f >= 6'h18 && f <= 6'h1b) return {1'b0, sp(C_MULT)};
            if (f == 6'h08) return {1'b0, sp(C_JR)};
            if (f == 6'h09) return {1'b0, sp(C_JALR)};
            if (i == 32'h0) return 13'h0;
            if (f inside {6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, [6'h20:6'h27], 6'h2a, 6'h2b})
                return {1'b0, sp(C_ALU)};
            return {1'b1, 12'h0};
        end
        if (op >= 6'h08 && op <= 6'h0b) return {1'b0, sp(C_IMMA)};
        if (op >= 6'h0c && op <= 6'h0f) return {1'b0, sp(C_IMML)};
        if (op inside {6'h20, 6'h21, 6'h23, 6'h24, 6'h25}) return {1'b0, sp(C_LOAD)};
        if (op inside {6'h28, 6'h29, 6'h2b}) return {1'b0, sp(C_STOR)};
        if (op >= 6'h04 && op <= 6'h07) return {1'b0, sp(C_BR)};
        if (op == 6'h01) begin
            if (rt inside {5'd0, 5'd1}) return {1'b0, sp(C_BR)};
            if (rt inside {5'd16, 5'd17}) return {1'b0, sp(C_BAL)};
            return {1'b1, 12'h0};
        end
        if (op == 6'h02) return {1'b0, sp(C_J)};
        if (op == 6'h03) return {1'b0, sp(C_JAL)};
        return {1'b1, 12'h0};
    endfunction

    wire [81:0] obs = {out_valid, in_ready, count, out_inst, out_pc, out_ctrl, out_ri};

    function automatic logic [81:0] expected();
        logic v;
        v = (q.size() != 0);
        if (!v) return {1'b0, 1'b1, 3'd0, 77'h0};
        return {1'b1, q.size() != DEPTH, 3'(q.size()), q[0].inst, q[0].pc, q[0].ctrl, q[0].ri};
    endfunction

    // Drives one cycle and advances the model past the clock edge
    task automatic tick(input logic iv, input logic [31:0] inst, input logic [31:0] pc,
                        input logic ordy, input logic fl);
        logic pu, po;
        logic [12:0] d;
        in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl;
        pu = iv && (q.size() < DEPTH);
        po = ordy && (q.size() > 0);
        d = ref_dec(inst);
        @(posedge clk);
        #1;
        if (fl) q.delete();
        else begin
            if (po) void'(q.pop_front());
            if (pu) q.push_back('{inst, pc, d[11:0], d[12]});
        end
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q.delete();
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (obs !== {1'b0, 1'b1, 3'd0, 77'h0}) begin
            errors++;
            $display("FAIL reset_state: got %h want %h", obs, {1'b0, 1'b1, 3'd0, 77'h0});
        end
    endtask

    task automatic test_fill();
        logic [31:0] insts [4] = '{32'h24010005, 32'h8C220000, 32'hAC220004, 32'h0C000010};
        for (int k = 0; k < 4; k++) begin
            tick(1'b1, insts[k], 32'hBFC00000 + 32'(4 * k), 1'b0, 1'b0);
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL fill_%0d: got %h want %h", k, obs, expected());
            end
        end
        checks++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: in_ready=%b count=%0d want 0/4", in_ready, count);
        end
        checks++;
        if (out_ctrl !== sp(C_IMMA) || out_pc !== 32'hBFC00000) begin
            errors++;
            $display("FAIL fill_head: ctrl=%h pc=%h want %h/bfc00000", out_ctrl, out_pc, sp(C_IMMA));
        end
        tick(1'b1, 32'h00000021, 32'h1234, 1'b0, 1'b0);
        checks++;
        if (obs !== expected() || count !== 3'd4) begin
            errors++;
            $display("FAIL full_drop: got %h want %h", obs, expected());
        end
    endtask

    task automatic test_drain();
        logic [11:0] want [4] = '{sp(C_LOAD), sp(C_STOR), sp(C_JAL), 12'h0};
        for (int k = 0; k < 4; k++) begin
            tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (obs !== expected() || out_ctrl !== want[k]) begin
                errors++;
                $display("FAIL drain_%0d: got %h want %h ctrl_want %h", k, obs, expected(), want[k]);
            end
        end
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL drain_empty: out_valid=%b count=%0d want 0/0", out_valid, count);
        end
    endtask

    task automatic test_back_to_back();
        tick(1'b1, 32'h00851020, 32'h100, 1'b0, 1'b0);
        tick(1'b1, 32'h3C081234, 32'h104, 1'b0, 1'b0);
        for (int k = 0; k < 10; k++) begin
            tick(1'b1, $urandom, 32'h108 + 32'(4 * k), 1'b1, 1'b0);
            checks++;
            if (obs !== expected() || count !== 3'd2) begin
                errors++;
                $display("FAIL b2b_%0d: got %h want %h", k, obs, expected());
            end
        end
        repeat (2) tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_flush();
        for (int k = 0; k < 3; k++) tick(1'b1, 32'h8C220000 + 32'(k), 32'h200 + 32'(4 * k), 1'b0, 1'b0);
        checks++;
        if (count !== 3'd3) begin
            errors++;
            $display("FAIL flush_pre: count=%0d want 3", count);
        end
        tick(1'b1, 32'hAC220004, 32'h20C, 1'b0, 1'b1);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0 || obs !== expected()) begin
            errors++;
            $display("FAIL flush_clear: got %h want %h", obs, expected());
        end
        tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL flush_dropped: out_valid=%b count=%0d want 0/0", out_valid, count);
        end
    endtask

    task automatic test_decode_special();
        logic [12:0] want [3] = '{13'h0, {1'b1, 12'h0}, {1'b0, sp(C_BAL)}};
        tick(1'b1, 32'h00000000, 32'h300, 1'b0, 1'b0);
        tick(1'b1, 32'h7C000000, 32'h304, 1'b0, 1'b0);
        tick(1'b1, 32'h0411FFFF, 32'h308, 1'b0, 1'b0);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if ({out_ri, out_ctrl} !== want[k] || out_valid !== 1'b1 || obs !== expected()) begin
                errors++;
                $display("FAIL special_%0d: ri_ctrl=%h want %h", k, {out_ri, out_ctrl}, want[k]);
            end
            tick(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_reset_mid();
        for (int k = 0; k < 3; k++) tick(1'b1, 32'h03E00008 + 32'(k << 11), 32'h400 + 32'(4 * k), 1'b0, 1'b0);
        in_valid = 1'b1; in_inst = 32'h24010005; out_ready = 1'b1; flush = 1'b1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
        q.delete();
        checks++;
        if (obs !== {1'b0, 1'b1, 3'd0, 77'h0}) begin
            errors++;
            $display("FAIL reset_mid: got %h want %h", obs, {1'b0, 1'b1, 3'd0, 77'h0});
        end
    endtask

    task automatic test_random();
        logic [31:0] inst;
        for (int k = 0; k < 400; k++) begin
            inst = $urandom;
            case ($urandom_range(0, 4))
                0: inst[31:26] = 6'h00;
                1: begin inst[31:26] = 6'h01; inst[20:16] = 5'($urandom_range(0, 3) == 0 ? $urandom : {$urandom_range(0, 1), 3'b000, $urandom_range(0, 1)}); end
                2: inst = 32'h0;
                default: ;
            endcase
            tick($urandom_range(0, 3) != 0, inst, $urandom, $urandom_range(0, 2) != 0, $urandom_range(0, 29) == 0);
            checks++;
            if (obs !== expected()) begin
                errors++;
                $display("FAIL random_%0d: got %h want %h", k, obs, expected());
            end
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_back_to_back();
        test_flush();
        test_decode_special();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
